alien_fleet_scheduler: RTL and testbench

- Sequences the alien formation's marching pattern: sweep right, drop, sweep left, drop, until the fleet lands or is destroyed.
- Owns the step-rate divider, the fleet origin registers (x, y) and the boundary checks.
- Emits one-cycle step strobes plus a motion code. Renderer and collision logic consume the origin; sprite animation consumes the strobe.
- March rate speeds up as `alive_count` falls.

---
 rtl/alien_fleet_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_alien_fleet_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_fleet_scheduler.sv
// Alien formation march sequencer: step-rate divider, fleet origin and edge handling.
// The fleet sweeps right, drops, sweeps left, drops, until it lands or is wiped out.
// The march period shortens as aliens are destroyed, down to a floor.
module alien_fleet_scheduler #(
    parameter int unsigned XW          = 10,
    parameter int unsigned YW          = 10,
    parameter int unsigned CW          = 6,
    parameter int unsigned PW          = 24,
    parameter int unsigned X_START     = 0,
    parameter int unsigned Y_START     = 32,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 540,
    parameter int unsigned STEP_X      = 4,
    parameter int unsigned STEP_Y      = 16,
    parameter int unsigned Y_LAND      = 400,
    parameter int unsigned MAX_ALIENS  = 40,
    parameter int unsigned BASE_PERIOD = 1000000,
    parameter int unsigned SPEED_STEP  = 20000,
    parameter int unsigned MIN_PERIOD  = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pause,
    input  logic [CW-1:0] alive_count,
    output logic [XW-1:0] fleet_x,
    output logic [YW-1:0] fleet_y,
    output logic [2:0]    motion,
    output logic          step,
    output logic          landed,
    output logic          cleared
);

    // Period arithmetic is carried one bit wider than PW+CW so the difference is signed-safe
    localparam int unsigned MW = PW + CW + 1;

    localparam logic [2:0] MOT_NONE  = 3'd0;
    localparam logic [2:0] MOT_LEFT  = 3'd1;
    localparam logic [2:0] MOT_RIGHT = 3'd2;
    localparam logic [2:0] MOT_DOWN  = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RIGHT   = 3'd1,
        S_LEFT    = 3'd2,
        S_LANDED  = 3'd3,
        S_CLEARED = 3'd4
    } state_e;

    state_e        state_q,   state_d;
    logic [XW-1:0] x_q,       x_d;
    logic [YW-1:0] y_q,       y_d;
    logic [2:0]    motion_q,  motion_d;
    logic          step_q,    step_d;
    logic          landed_q,  landed_d;
    logic          cleared_q, cleared_d;
    logic [PW-1:0] counter_q, counter_d;
    logic [PW-1:0] period_q,  period_d;

    logic [CW-1:0]        alive_sat_c;
    logic [MW-1:0]        dead_c;
    logic [MW-1:0]        reduce_c;
    logic signed [MW-1:0] raw_c;
    logic [PW-1:0]        period_c;
    logic [XW:0]          x_sum_c;
    logic                 x_near_min_c;
    logic [YW:0]          y_sum_c;
    logic                 do_drop;

    // Step period for the current alive count, clamped to the floor
    always_comb begin
        alive_sat_c = (alive_count > CW'(MAX_ALIENS)) ? CW'(MAX_ALIENS) : alive_count;
        dead_c      = MW'(MAX_ALIENS) - MW'(alive_sat_c);
        reduce_c    = dead_c * MW'(SPEED_STEP);
        raw_c       = $signed(MW'(BASE_PERIOD) - reduce_c);
        period_c    = (raw_c < $signed(MW'(MIN_PERIOD))) ? PW'(MIN_PERIOD) : PW'(raw_c);
    end

    // Candidate positions, computed one bit wide so edge clamps never wrap
    always_comb begin
        x_sum_c      = {1'b0, x_q} + (XW + 1)'(STEP_X);
        x_near_min_c = ({1'b0, x_q} <= (XW + 1)'(X_MIN + STEP_X));
        y_sum_c      = {1'b0, y_q} + (YW + 1)'(STEP_Y);
    end

    // Next-state and next-output logic for the march sequencer
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        motion_d  = motion_q;
        step_d    = 1'b0;
        landed_d  = landed_q;
        cleared_d = cleared_q;
        counter_d = counter_q;
        period_d  = period_q;
        do_drop   = 1'b0;

        case (state_q)
            S_RIGHT, S_LEFT: begin
                if (alive_count == '0) begin
                    // Wipe-out wins over any step due this cycle
                    state_d   = S_CLEARED;
                    cleared_d = 1'b1;
                end else if (!pause) begin
                    if (counter_q == period_q - PW'(1)) begin
                        counter_d = '0;
                        step_d    = 1'b1;
                        period_d  = period_c;
                        if (state_q == S_RIGHT) begin
                            if (x_q == XW'(X_MAX)) begin
                                do_drop = 1'b1;
                            end else begin
                                x_d      = (x_sum_c >= (XW + 1)'(X_MAX)) ? XW'(X_MAX)
                                                                          : x_sum_c[XW-1:0];
                                motion_d = MOT_RIGHT;
                            end
                        end else begin
                            if (x_q == XW'(X_MIN)) begin
                                do_drop = 1'b1;
                            end else begin
                                x_d      = x_near_min_c ? XW'(X_MIN) : x_q - XW'(STEP_X);
                                motion_d = MOT_LEFT;
                            end
                        end
                        if (do_drop) begin
                            y_d      = y_sum_c[YW-1:0];
                            motion_d = MOT_DOWN;
                            if (y_sum_c >= (YW + 1)'(Y_LAND)) begin
                                state_d  = S_LANDED;
                                landed_d = 1'b1;
                            end else begin
                                state_d = (state_q == S_RIGHT) ? S_LEFT : S_RIGHT;
                            end
                        end
                    end else begin
                        counter_d = counter_q + PW'(1);
                    end
                end
            end
            default: begin
                // IDLE, LANDED, CLEARED: fleet parked until a new wave starts
                motion_d = MOT_NONE;
                if (start) begin
                    state_d   = S_RIGHT;
                    x_d       = XW'(X_START);
                    y_d       = YW'(Y_START);
                    landed_d  = 1'b0;
                    cleared_d = 1'b0;
                    counter_d = '0;
                    period_d  = period_c;
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            x_q       <= XW'(X_START);
            y_q       <= YW'(Y_START);
            motion_q  <= MOT_NONE;
            step_q    <= 1'b0;
            landed_q  <= 1'b0;
            cleared_q <= 1'b0;
            counter_q <= '0;
            period_q  <= PW'(BASE_PERIOD);
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            motion_q  <= motion_d;
            step_q    <= step_d;
            landed_q  <= landed_d;
            cleared_q <= cleared_d;
            counter_q <= counter_d;
            period_q  <= period_d;
        end
    end

    assign fleet_x = x_q;
    assign fleet_y = y_q;
    assign motion  = motion_q;
    assign step    = step_q;
    assign landed  = landed_q;
    assign cleared = cleared_q;

endmodule

// File: tb/tb_alien_fleet_scheduler.sv
// Scoreboard bench for alien_fleet_scheduler with a small-scale configuration.
// Instance A uses X_MAX=8, instance B uses X_MAX=10 for the edge-clamp sweep.
module tb_alien_fleet_scheduler;

    typedef struct {
        int gap;
        int x;
        int y;
        int m;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic       pause;
    logic [5:0] alive;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic [2:0] m_a, m_b;
    logic       step_a, landed_a, cleared_a;
    logic       step_b, landed_b, cleared_b;

    logic start_q_a = 1'b0;
    logic start_q_b = 1'b0;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alien_fleet_scheduler #(
        .X_START(0), .Y_START(0), .X_MIN(0), .X_MAX(8), .STEP_X(4), .STEP_Y(2),
        .Y_LAND(6), .MAX_ALIENS(4), .BASE_PERIOD(4), .SPEED_STEP(1), .MIN_PERIOD(2)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .pause(pause), .alive_count(alive),
        .fleet_x(x_a), .fleet_y(y_a), .motion(m_a), .step(step_a),
        .landed(landed_a), .cleared(cleared_a)
    );

    alien_fleet_scheduler #(
        .X_START(0), .Y_START(0), .X_MIN(0), .X_MAX(10), .STEP_X(4), .STEP_Y(2),
        .Y_LAND(6), .MAX_ALIENS(4), .BASE_PERIOD(4), .SPEED_STEP(1), .MIN_PERIOD(2)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .pause(pause), .alive_count(alive),
        .fleet_x(x_b), .fleet_y(y_b), .motion(m_b), .step(step_b),
        .landed(landed_b), .cleared(cleared_b)
    );

    // Marks the edge that accepted a start so the monitor can time the first step
    always @(posedge clk) begin
        start_q_a <= start_a;
        start_q_b <= start_b;
    end

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void cmp_step(string tag, bit have, exp_t e, int gap, int x, int y, int m);
        n_cmp++;
        if (!have) begin
            n_bad++;
            $display("FAIL %s unexpected step: gap=%0d x=%0d y=%0d motion=%0d", tag, gap, x, y, m);
        end else if (gap != e.gap || x != e.x || y != e.y || m != e.m) begin
            n_bad++;
            $display("FAIL %s step: got gap=%0d x=%0d y=%0d motion=%0d expected gap=%0d x=%0d y=%0d motion=%0d",
                     tag, gap, x, y, m, e.gap, e.x, e.y, e.m);
        end
    endfunction

    function automatic exp_t mk(int gap, int x, int y, int m);
        exp_t e;
        e.gap = gap;
        e.x   = x;
        e.y   = y;
        e.m   = m;
        return e;
    endfunction

    // Monitor: counts clocks since the last start/step and checks every strobe
    initial begin
        int   ctr_a = 0;
        int   ctr_b = 0;
        bit   have;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset || start_q_a) ctr_a = 0; else ctr_a = ctr_a + 1;
            if (!reset || start_q_b) ctr_b = 0; else ctr_b = ctr_b + 1;
            if (step_a) begin
                have = (q_a.size() != 0);
                e    = have ? q_a.pop_front() : mk(0, 0, 0, 0);
                cmp_step("A", have, e, ctr_a, int'(x_a), int'(y_a), int'(m_a));
                ctr_a = 0;
            end
            if (step_b) begin
                have = (q_b.size() != 0);
                e    = have ? q_b.pop_front() : mk(0, 0, 0, 0);
                cmp_step("B", have, e, ctr_b, int'(x_b), int'(y_b), int'(m_b));
                ctr_b = 0;
            end
        end
    end

    task automatic pulse_start(input bit sel_b);
        @(negedge clk);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drain(input bit sel_b, input int maxc);
        int n = 0;
        while ((sel_b ? q_b.size() : q_a.size()) != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if ((sel_b ? q_b.size() : q_a.size()) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_%s: got %0d pending steps expected 0", sel_b ? "B" : "A",
                     sel_b ? q_b.size() : q_a.size());
            if (sel_b) q_b.delete(); else q_a.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        pause   = 1'b0;
        alive   = 6'd4;

        // Reset values
        #3;
        chk("rst_x", int'(x_a), 0);
        chk("rst_y", int'(y_a), 0);
        chk("rst_motion", int'(m_a), 0);
        chk("rst_step", int'(step_a), 0);
        chk("rst_landed", int'(landed_a), 0);
        chk("rst_cleared", int'(cleared_a), 0);
        chk("rst_x_b", int'(x_b), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Full march to landing
        q_a.push_back(mk(4, 4, 0, 2));
        q_a.push_back(mk(4, 8, 0, 2));
        q_a.push_back(mk(4, 8, 2, 3));
        q_a.push_back(mk(4, 4, 2, 1));
        q_a.push_back(mk(4, 0, 2, 1));
        q_a.push_back(mk(4, 0, 4, 3));
        q_a.push_back(mk(4, 4, 4, 2));
        q_a.push_back(mk(4, 8, 4, 2));
        q_a.push_back(mk(4, 8, 6, 3));
        pulse_start(1'b0);
        drain(1'b0, 60);
        repeat (6) @(negedge clk);
        chk("land_flag", int'(landed_a), 1);
        chk("land_x", int'(x_a), 8);
        chk("land_y", int'(y_a), 6);
        chk("land_motion", int'(m_a), 0);

        // Speed-up: alive drops mid-interval, floor period afterwards
        alive = 6'd4;
        q_a.push_back(mk(4, 4, 0, 2));
        q_a.push_back(mk(2, 8, 0, 2));
        q_a.push_back(mk(2, 8, 2, 3));
        pulse_start(1'b0);
        chk("restart_landed", int'(landed_a), 0);
        repeat (2) @(negedge clk);
        alive = 6'd1;
        drain(1'b0, 30);
        alive = 6'd0;
        repeat (2) @(negedge clk);
        chk("spd_cleared", int'(cleared_a), 1);
        chk("spd_x", int'(x_a), 8);
        chk("spd_y", int'(y_a), 2);

        // Cleared wins over a step due in the same cycle
        alive = 6'd4;
        pulse_start(1'b0);
        chk("clr_start_x", int'(x_a), 0);
        chk("clr_start_cleared", int'(cleared_a), 0);
        repeat (3) @(negedge clk);
        alive = 6'd0;
        @(negedge clk);
        chk("clr_step", int'(step_a), 0);
        chk("clr_cleared", int'(cleared_a), 1);
        chk("clr_x", int'(x_a), 0);
        chk("clr_y", int'(y_a), 0);

        // Restart, then pause at counter=2 for 10 clocks
        alive = 6'd4;
        q_a.push_back(mk(14, 4, 0, 2));
        q_a.push_back(mk(4, 8, 0, 2));
        q_a.push_back(mk(4, 8, 2, 3));
        pulse_start(1'b0);
        chk("rs_x", int'(x_a), 0);
        chk("rs_y", int'(y_a), 0);
        chk("rs_cleared", int'(cleared_a), 0);
        repeat (2) @(negedge clk);
        pause = 1'b1;
        repeat (10) @(negedge clk);
        pause = 1'b0;
        drain(1'b0, 40);
        chk("pre_rst_x", int'(x_a), 8);
        chk("pre_rst_y", int'(y_a), 2);

        // Asynchronous reset between edges mid-wave
        #2;
        reset = 1'b0;
        #1;
        chk("arst_x", int'(x_a), 0);
        chk("arst_y", int'(y_a), 0);
        chk("arst_motion", int'(m_a), 0);
        chk("arst_step", int'(step_a), 0);
        chk("arst_landed", int'(landed_a), 0);
        chk("arst_cleared", int'(cleared_a), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("idle_x", int'(x_a), 0);
        chk("idle_y", int'(y_a), 0);
        chk("idle_motion", int'(m_a), 0);

        // Edge clamp on instance B (X_MAX=10)
        alive = 6'd4;
        q_b.push_back(mk(4, 4, 0, 2));
        q_b.push_back(mk(4, 8, 0, 2));
        q_b.push_back(mk(4, 10, 0, 2));
        q_b.push_back(mk(4, 10, 2, 3));
        q_b.push_back(mk(4, 6, 2, 1));
        q_b.push_back(mk(4, 2, 2, 1));
        q_b.push_back(mk(4, 0, 2, 1));
        q_b.push_back(mk(4, 0, 4, 3));
        q_b.push_back(mk(4, 4, 4, 2));
        q_b.push_back(mk(4, 8, 4, 2));
        q_b.push_back(mk(4, 10, 4, 2));
        q_b.push_back(mk(4, 10, 6, 3));
        pulse_start(1'b1);
        drain(1'b1, 80);
        repeat (6) @(negedge clk);
        chk("b_landed", int'(landed_b), 1);
        chk("b_x", int'(x_b), 10);
        chk("b_y", int'(y_b), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
